// File: rtl/dmem_copy_engine.sv
// Word-granular copy/fill engine that masters a single-cycle data-memory port.
// Copy alternates READ/WRITE per word; fill streams WRITE cycles back to back.
module dmem_copy_engine #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      pattern,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      pat_q, pat_d;
  logic             mode_q, mode_d;
  logic             error_q, error_d;
  logic             misaligned;

  // Source alignment only matters when the source is actually read.
  assign misaligned = (~mode & (|src_addr[1:0])) | (|dst_addr[1:0]);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    error_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = count;
          pat_d  = pattern;
          mode_d = mode;
          if (misaligned) begin
            error_d = 1'b1;
          end else if (count == '0) begin
            state_d = StFin;
          end else begin
            state_d = mode ? StWrite : StRead;
          end
        end
      end
      StRead: begin
        data_d  = mem_rd;
        state_d = StWrite;
      end
      StWrite: begin
        src_d = src_q + 32'd4;
        dst_d = dst_q + 32'd4;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StFin;
        end else begin
          state_d = mode_q ? StWrite : StRead;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      pat_q   <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (state_q)
      StRead: begin
        mem_a = src_q;
      end
      StWrite: begin
        mem_we = 1'b1;
        mem_a  = dst_q;
        mem_wd = mode_q ? pat_q : data_q;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign busy  = (state_q == StRead) || (state_q == StWrite);
  assign done  = (state_q == StFin);
  assign error = error_q;

endmodule

// File: doc/dmem_copy_engine.md
DMEM_COPY_ENGINE -- requirements
Module: dmem_copy_engine

Interface
REQ-001 Parameter: CNT_W, default 7, width of the word-count input (maximum 127 words).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: mode  input  1  operation select: 0 = copy, 1 = fill.
REQ-006 Port: src_addr  input  32  source byte address (copy mode).
REQ-007 Port: dst_addr  input  32  destination byte address.
REQ-008 Port: count  input  CNT_W  number of 32-bit words to transfer.
REQ-009 Port: pattern  input  32  fill word (fill mode).
REQ-010 Port: mem_we  output  1  data-memory write enable.
REQ-011 Port: mem_a  output  32  data-memory byte address.
REQ-012 Port: mem_wd  output  32  data-memory write data.
REQ-013 Port: mem_rd  input  32  data-memory read data, combinational from mem_a within the same cycle.
REQ-014 Port: busy  output  1  high while in READ or WRITE.
REQ-015 Port: done  output  1  one-cycle completion pulse.
REQ-016 Port: error  output  1  one-cycle pulse on a rejected request.

Function
REQ-017 The engine SHALL be the initiator on the data-memory port: writes commit at the clk edge when mem_we=1, and reads return data in the same cycle.
REQ-018 The FSM SHALL have exactly the states IDLE, READ, WRITE and FIN.
REQ-019 In IDLE, start=1 SHALL latch src_addr, dst_addr, count, mode and pattern into internal registers; later input changes SHALL have no effect until the engine returns to IDLE.
REQ-020 In IDLE, start=1 with src_addr[1:0]!=0 (copy mode only) or dst_addr[1:0]!=0 SHALL cause:
  - a one-cycle error pulse on the next cycle;
  - a stay in IDLE;
  - no memory access.
REQ-021 In IDLE, an aligned start with count=0 SHALL go to FIN with no memory access.
REQ-022 In IDLE, an aligned start with count!=0 SHALL go to READ (mode=0) or WRITE (mode=1).
REQ-023 In READ:
  - mem_a SHALL equal the current source pointer and mem_we SHALL be 0;
  - mem_rd SHALL be captured into a data register at the clk edge;
  - the next state SHALL be WRITE.
REQ-024 In WRITE:
  - mem_a SHALL equal the current destination pointer and mem_we SHALL be 1;
  - mem_wd SHALL be the data register (copy mode) or pattern (fill mode);
  - the source and destination pointers SHALL each increment by 4, and the remaining count SHALL decrement by 1.
REQ-025 After WRITE, the FSM SHALL go to FIN when the remaining count was 1 before the decrement; otherwise it SHALL go to READ (copy mode) or stay in WRITE (fill mode).
REQ-026 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 Pointer arithmetic SHALL be 32-bit modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0x0000_0000 without error.
REQ-028 A start asserted while not in IDLE SHALL be ignored and not queued.
REQ-029 Latency from the start edge to the done pulse:
  - copy: 2N+1 cycles, with busy high for 2N cycles;
  - fill: N+1 cycles, with busy high for N cycles;
  - count=0: done on the next cycle, busy never high.
REQ-030 mem_we SHALL be 1 only in WRITE.
REQ-031 In IDLE and FIN, mem_a and mem_wd SHALL be 0.
REQ-032 The engine SHALL NOT decode addresses; peripheral addresses (e.g. 0xC000_0004) are written like any other address.
REQ-033 Overlapping source and destination regions SHALL be processed in strictly ascending address order, with no overlap correction.

Reset
REQ-034 Reset SHALL force:
  - state = IDLE;
  - mem_we, busy, done, error = 0;
  - mem_a, mem_wd, pointers, count register and data register = 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer at that edge, leaving no further write and no done pulse.
REQ-036 Reset SHALL take priority over start in the same cycle.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
  - Copy, src=0x00, dst=0x40, count=3, RAM[0..2]=A,B,C → writes A,B,C to 0x40, 0x44, 0x48 on cycles 2, 4, 6; done on cycle 7; busy high for 6 cycles.
  - Fill, dst=0x10, count=4, pattern=0xDEADBEEF → 4 consecutive write cycles to 0x10..0x1C; done on cycle 5.
  - count=0 → done 1 cycle after start; mem_we never 1.
  - dst=0x42 → error pulse; no write; next aligned start accepted normally.
  - Reset asserted after the 2nd write of a count=5 copy → mem_we=0 from that edge on, no done, state IDLE; a second start during busy is ignored.
  - Fill starting at dst=0xFFFF_FFF8 with count=3 → writes to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
